// File: rtl/temp_ram_pkg.sv
// Shared definitions for the temperature RAM scheduler: port-owner states,
// default geometry and arbitration limits.
package temp_ram_pkg;

    localparam int unsigned ADDR_W_DEF     = 7;
    localparam int unsigned STARVE_LIM_DEF = 8;
    localparam int unsigned DATA_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10
    } port_state_t;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle
// pulse on each synchronised rising edge.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= level;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign pulse = sync & ~sync_q;

endmodule

// File: rtl/temp_ram_sched.sv
// Single-port RAM scheduler for double-buffered temperature frames: arbitrates
// reader and sensor writer onto the RAM port and swaps banks on frame edges.
module temp_ram_sched
    import temp_ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              wr_done,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rd_bank,
    output logic              bank_swapped,
    output logic [7:0]        stale_cnt,
    output logic              overrun
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    port_state_t         state;
    port_state_t         state_next;
    logic [STARVE_W-1:0] starve;
    logic                starve_hit;
    logic                rd_pipe;
    logic                frame_edge;
    logic                swap_pend;
    logic                swap_now;

    sync_rise_det u_sw_sync (
        .clk   (clk),
        .rst   (rst),
        .level (sw),
        .pulse (frame_edge)
    );

    assign starve_hit = (starve == STARVE_MAX);

    // A starved writer pre-empts a waiting reader for exactly one grant.
    always_comb begin
        state_next = ST_IDLE;
        if (wr_req && (starve_hit || !rd_req)) begin
            state_next = ST_WR;
        end else if (rd_req) begin
            state_next = ST_RD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign rd_ack = (state == ST_RD);
    assign wr_ack = (state == ST_WR);
    assign ram_we = (state == ST_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state_next)
                ST_RD: ram_addr <= {rd_bank, rd_addr};
                ST_WR: begin
                    ram_addr  <= {~rd_bank, wr_addr};
                    ram_wdata <= wr_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (state_next == ST_WR) begin
            starve <= '0;
        end else if (wr_req && !starve_hit) begin
            starve <= starve + 1'b1;
        end
    end

    // RAM answers one cycle after the address; capture it one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pipe  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pipe  <= rd_ack;
            rd_valid <= rd_pipe;
            if (rd_pipe) begin
                rd_data <= ram_rdata;
            end
        end
    end

    assign swap_now = frame_edge && (swap_pend || wr_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank      <= 1'b0;
            swap_pend    <= 1'b0;
            bank_swapped <= 1'b0;
            stale_cnt    <= '0;
            overrun      <= 1'b0;
        end else begin
            bank_swapped <= swap_now;
            if (wr_done && swap_pend) begin
                overrun <= 1'b1;
            end
            if (swap_now) begin
                rd_bank   <= ~rd_bank;
                swap_pend <= 1'b0;
                stale_cnt <= '0;
            end else begin
                if (wr_done) begin
                    swap_pend <= 1'b1;
                end
                if (frame_edge && (stale_cnt != 8'hFF)) begin
                    stale_cnt <= stale_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_ram_sched.sv
// Self-checking bench for temp_ram_sched: cycle reference model plus RAM model,
// directed scenarios for the listed behaviours and a randomized traffic phase.
module tb_temp_ram_sched;

    localparam int STARVE_LIM = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw = 1'b0;
    logic       rd_req = 1'b0;
    logic [6:0] rd_addr = '0;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_req = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ack;
    logic       wr_done = 1'b0;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       rd_bank;
    logic       bank_swapped;
    logic [7:0] stale_cnt;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    temp_ram_sched #(.ADDR_W(7), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_done(wr_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .rd_bank(rd_bank),
        .bank_swapped(bank_swapped), .stale_cnt(stale_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Synchronous RAM: data for an address appears one cycle later.
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model, evaluated at each rising edge from the sampled inputs.
    logic [7:0] mm [0:255];
    logic       e_rd_ack = 0, e_wr_ack = 0, e_swapped = 0, e_rd_valid = 0;
    logic [7:0] e_rd_data = 0, e_ram_addr = 0, e_wdata = 0;
    logic       m_bank = 0, m_pend = 0, m_ov = 0;
    int         m_stale = 0, m_starve = 0;
    logic       h0 = 0, h1 = 0, h2 = 0;
    logic       pv0 = 0, pv1 = 0;
    logic [7:0] pd0 = 0, pd1 = 0;
    logic       fe, gw, gr;

    always @(posedge clk) begin
        if (!rst) begin
            e_rd_ack = 0; e_wr_ack = 0; e_swapped = 0; e_rd_valid = 0;
            e_rd_data = 0; e_ram_addr = 0; e_wdata = 0;
            m_bank = 0; m_pend = 0; m_ov = 0; m_stale = 0; m_starve = 0;
            h0 = 0; h1 = 0; h2 = 0; pv0 = 0; pv1 = 0;
        end else begin
            // sw seen two edges ago high and three edges ago low
            fe = h1 && !h2;
            h2 = h1; h1 = h0; h0 = sw;
            gw = wr_req && (m_starve == STARVE_LIM || !rd_req);
            gr = rd_req && !gw;
            e_rd_valid = pv1;
            if (pv1) e_rd_data = pd1;
            pv1 = pv0; pd1 = pd0;
            pv0 = gr;  pd0 = mm[{m_bank, rd_addr}];
            e_rd_ack = gr;
            e_wr_ack = gw;
            if (gr) e_ram_addr = {m_bank, rd_addr};
            if (gw) begin
                e_ram_addr = {~m_bank, wr_addr};
                e_wdata = wr_data;
                mm[e_ram_addr] = wr_data;
            end
            if (gw) m_starve = 0;
            else if (wr_req && m_starve < STARVE_LIM) m_starve++;
            if (wr_done && m_pend) m_ov = 1;
            if (fe && (m_pend || wr_done)) begin
                m_bank = ~m_bank; m_pend = 0; m_stale = 0; e_swapped = 1;
            end else begin
                e_swapped = 0;
                if (fe && m_stale < 255) m_stale++;
                if (wr_done) m_pend = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("rd_ack", rd_ack, e_rd_ack);
        chk("wr_ack", wr_ack, e_wr_ack);
        chk("ram_we", ram_we, e_wr_ack);
        chk("rd_valid", rd_valid, e_rd_valid);
        chk("bank_swapped", bank_swapped, e_swapped);
        chk("rd_bank", rd_bank, m_bank);
        chk("stale_cnt", stale_cnt, m_stale);
        chk("overrun", overrun, m_ov);
        if (e_rd_ack || e_wr_ack) chk("ram_addr", ram_addr, e_ram_addr);
        if (e_wr_ack) chk("ram_wdata", ram_wdata, e_wdata);
        if (e_rd_valid) chk("rd_data", rd_data, e_rd_data);
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {rd_ack, rd_valid, wr_ack, ram_we, rd_bank, bank_swapped, overrun}, 0);
        chk({nm, "_data"}, {rd_data, ram_addr, ram_wdata, stale_cnt}, 0);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        bit ok;
        ok = 0;
        wr_req = 1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (wr_ack) ok = 1;
        end
        chk("write_ack_timeout", ok, 1);
        wr_req = 0;
    endtask

    task automatic pulse_done();
        @(negedge clk); wr_done = 1;
        @(negedge clk); wr_done = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ram[i] = v; mm[i] = v;
        end
        ram[5] = 8'h3C; mm[5] = 8'h3C;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset_init");
        rst = 1;

        // Single read of bank 0, address 5
        @(negedge clk);
        rd_req = 1; rd_addr = 7'd5;
        @(negedge clk);
        chk("lit_rd_ack", rd_ack, 1);
        chk("lit_rd_addr", ram_addr, 8'h05);
        rd_req = 0;
        @(negedge clk);
        chk("lit_rd_valid_early", rd_valid, 0);
        @(negedge clk);
        chk("lit_rd_valid", rd_valid, 1);
        chk("lit_rd_data", rd_data, 8'h3C);

        // Continuous reads starve a writer until the limit forces it in
        rd_req = 1; rd_addr = 7'($urandom);
        wr_req = 1; wr_addr = 7'($urandom); wr_data = 8'($urandom);
        got = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(negedge clk);
            if (wr_ack) begin
                got = c;
                chk("lit_rd_gap", rd_ack, 0);
                wr_req = 0;
            end else begin
                chk("lit_rd_stream", rd_ack, 1);
                rd_addr = 7'($urandom);
            end
        end
        chk("lit_wr_ack_cycle", got, 9);
        @(negedge clk);
        chk("lit_rd_resume", rd_ack, 1);
        rd_req = 0;
        repeat (3) @(negedge clk);

        // Fill the write bank, finish it, then raise the frame switch
        for (int i = 0; i < 128; i++) do_write(7'(i), 8'($urandom));
        pulse_done();
        sw = 1;
        got = 0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            @(negedge clk);
            if (bank_swapped) got = c;
        end
        chk("lit_swap_latency", got, 3);
        chk("lit_swap_bank", rd_bank, 1);
        chk("lit_swap_stale", stale_cnt, 0);

        // Freshly written bank is now readable
        rd_req = 1; rd_addr = 7'd17;
        @(negedge clk); rd_req = 0;
        repeat (3) @(negedge clk);

        // wr_done coincident with the synchronised frame edge
        sw = 0;
        repeat (5) @(negedge clk);
        sw = 1;
        @(negedge clk);
        @(negedge clk);
        wr_done = 1;
        @(negedge clk);
        wr_done = 0;
        chk("lit_coinc_swap", bank_swapped, 1);
        chk("lit_coinc_bank", rd_bank, 0);
        chk("lit_coinc_stale", stale_cnt, 0);
        chk("lit_coinc_overrun", overrun, 0);

        // Frame edges with no fresh bank, then a double wr_done
        sw = 0;
        repeat (5) @(negedge clk);
        repeat (3) begin
            sw = 1; repeat (4) @(negedge clk);
            sw = 0; repeat (4) @(negedge clk);
        end
        chk("lit_stale3", stale_cnt, 3);
        chk("lit_stale_bank", rd_bank, 0);
        pulse_done();
        @(negedge clk);
        chk("lit_overrun_first", overrun, 0);
        pulse_done();
        @(negedge clk);
        chk("lit_overrun", overrun, 1);

        // Reset clears everything, then randomized traffic
        rst = 0; #1;
        chk_all_zero("reset_mid");
        repeat (3) @(negedge clk);
        rst = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wr_done = 0;
            if (rd_req && rd_ack) rd_req = 0;
            if (!rd_req && $urandom_range(0, 3) != 0) begin
                rd_req = 1; rd_addr = 7'($urandom);
            end
            if (wr_req && wr_ack) wr_req = 0;
            if (!wr_req && $urandom_range(0, 1) != 0) begin
                wr_req = 1; wr_addr = 7'($urandom); wr_data = 8'($urandom);
            end
            if ($urandom_range(0, 59) == 0) wr_done = 1;
            if ($urandom_range(0, 15) == 0) sw = ~sw;
        end
        @(negedge clk);
        wr_done = 0; wr_req = 0;
        if (rd_req && rd_ack) rd_req = 0;
        got = 0;
        for (int c = 0; c < 20 && rd_req; c++) begin
            @(negedge clk);
            if (rd_ack) rd_req = 0;
        end
        repeat (4) @(negedge clk);

        // Reset one cycle after a read grant abandons the read
        rd_req = 1; rd_addr = 7'($urandom);
        got = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(negedge clk);
            if (rd_ack) got = c;
        end
        chk("lit_abort_ack", got, 1);
        rd_req = 0;
        @(negedge clk);
        rst = 0; #1;
        chk_all_zero("reset_abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("lit_abort_no_valid", rd_valid, 0);
        end
        rst = 1;
        rd_req = 1; rd_addr = 7'd5;
        @(negedge clk);
        chk("lit_no_init_cycle", rd_ack, 1);
        rd_req = 0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/temp_ram_sched.md
TEMP_RAM_SCHED -- requirements
Module: temp_ram_sched

Interface
REQ-001 Parameter: ADDR_W, 7, per-bank word address width (128 temperature bytes per bank).
REQ-002 Parameter: STARVE_LIM, 8, wait cycles after which a pending write is forced ahead of reads.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sw  input  1  frame-switch level from frame former, asynchronous to clk.
REQ-006 rd_req  input  1  reader request level, held until rd_ack.
REQ-007 rd_addr  input  ADDR_W  reader byte address within current read bank.
REQ-008 rd_ack  output  1  one-cycle pulse, read accepted.
REQ-009 rd_data  output  8  read byte, registered.
REQ-010 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-011 wr_req  input  1  sensor-writer request level, held until wr_ack.
REQ-012 wr_addr  input  ADDR_W  writer byte address within write bank.
REQ-013 wr_data  input  8  byte to write.
REQ-014 wr_ack  output  1  one-cycle pulse, write performed.
REQ-015 wr_done  input  1  one-cycle pulse, writer finished a complete bank.
REQ-016 ram_addr  output  ADDR_W+1  registered RAM address {bank, word}.
REQ-017 ram_we  output  1  registered RAM write enable.
REQ-018 ram_wdata  output  8  registered RAM write data.
REQ-019 ram_rdata  input  8  RAM read data, valid one cycle after ram_addr.
REQ-020 rd_bank  output  1  bank currently read; writer uses ~rd_bank.
REQ-021 bank_swapped  output  1  one-cycle pulse on bank swap.
REQ-022 stale_cnt  output  8  frames served without fresh bank, saturating.
REQ-023 overrun  output  1  sticky: wr_done while swap already pending.

Function
REQ-024 sw shall pass a 2-FF synchroniser; frame edge = synchronised rising edge, one cycle.
REQ-025 Port state machine IDLE/RD/WR shall give RAM-port owner each cycle; next state chosen every edge from requests, no dead cycle between grants.
REQ-026 Arbitration: rd_req wins over wr_req unless starve counter equals STARVE_LIM, then WR granted that edge.
REQ-027 Starve counter increments each cycle wr_req high and not granted, saturates at STARVE_LIM, clears on wr_ack.
REQ-028 RD grant at edge k: rd_ack=1, ram_addr={rd_bank,rd_addr}, ram_we=0; rd_data=ram_rdata and rd_valid=1 at edge k+2 (latency 2).
REQ-029 WR grant at edge k: wr_ack=1, ram_addr={~rd_bank,wr_addr}, ram_we=1, ram_wdata=wr_data; ram_we low in all non-WR cycles.
REQ-030 Forced write with rd_req high shall delay rd_ack by exactly one cycle; read never lost.
REQ-031 Back-to-back reads at one per cycle shall be sustained with rd_valid every cycle.
REQ-032 wr_done shall set swap_pend; frame edge with swap_pend shall toggle rd_bank, clear swap_pend, pulse bank_swapped.
REQ-033 Frame edge without swap_pend: rd_bank unchanged, stale_cnt+1 saturating at 255; cleared on any swap.
REQ-034 wr_done and frame edge in same cycle: swap occurs, stale_cnt not incremented.
REQ-035 wr_done while swap_pend already set: overrun sets, held until reset.
REQ-036 Swap while read in flight: in-flight read completes from bank latched at its grant.

Reset
REQ-037 rst low shall immediately force state IDLE, rd_bank=0, all pulses/ram_we/rd_data/ram_addr/ram_wdata=0, stale_cnt=0, overrun=0, swap_pend=0, starve counter=0, synchroniser=0.
REQ-038 Reset mid-transaction shall abandon in-flight read without rd_valid; release requires no extra init cycle.

Structure
REQ-039 Shared package temp_ram_pkg shall hold state enum, ADDR_W and STARVE_LIM defaults, data width 8.
REQ-040 One sub-module sync_rise_det (2-FF synchroniser plus rising-edge pulse) shall be instantiated for sw.

Verification
REQ-041 rd_req held, rd_addr=5, bank 0 preloaded 0x3C -> rd_ack at edge k, rd_valid with rd_data=0x3C at k+2.
REQ-042 rd_req held continuously, wr_req raised -> wr_ack on 9th cycle (STARVE_LIM=8), rd_ack gap of exactly one cycle.
REQ-043 Writer fills 128 bytes, wr_done, then sw rise -> bank_swapped after 3 clocks, rd_bank=1, stale_cnt=0.
REQ-044 Three sw rises without wr_done -> stale_cnt=3; wr_done twice without sw -> overrun=1.
REQ-045 wr_done coincident with synchronised frame edge -> swap, stale_cnt unchanged.
REQ-046 rst asserted one cycle after rd_ack -> no rd_valid, all outputs zero during reset.
